// File: rtl/gate_bank_checker_pkg.sv
// Shared types and constants for the gate bank checker and its reference model.
// Bit positions follow the gate bank output bus {nand,xor,not_b,not_a,or,and}.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_NOTA = 2;
    localparam int IDX_NOTB = 3;
    localparam int IDX_XOR  = 4;
    localparam int IDX_NAND = 5;

    localparam int NUM_VEC = 4;

    // Golden response of the six-gate bank for one input pair.
    function automatic logic [5:0] gate_expected(input logic a, input logic b);
        logic [5:0] g;
        g           = 6'b000000;
        g[IDX_AND]  = a & b;
        g[IDX_OR]   = a | b;
        g[IDX_NOTA] = ~a;
        g[IDX_NOTB] = ~b;
        g[IDX_XOR]  = a ^ b;
        g[IDX_NAND] = ~(a & b);
        return g;
    endfunction

endpackage

// File: rtl/gate_bank_checker_if.sv
// Bundle of stimulus, response and result signals between the checker and the gate bank / LEDs.
// The master side is the checker itself; the slave side is its environment.
interface gate_bank_checker_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             a;
    logic             b;
    logic [5:0]       dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       fail_vec;
    logic [5:0]       fail_mask;

    modport master (
        input  start, dut_out,
        output a, b, busy, done, pass, err_count, fail_vec, fail_mask
    );

    modport slave (
        output start, dut_out,
        input  a, b, busy, done, pass, err_count, fail_vec, fail_mask
    );
endinterface

// File: rtl/gate_bank_checker_ref_model.sv
// Combinational golden model of the 2-input gate bank; shared with other lab checkers.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    output logic [5:0] o_expected
);

    assign o_expected = gate_expected(i_a, i_b);

endmodule

// File: rtl/gate_bank_checker.sv
// Stimulus/response engine: walks the four (a,b) vectors, compares the gate bank against
// the reference model and keeps LED-friendly results (pass, error count, first vector, mask).
module gate_bank_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 3
)(
    input  logic                clk,
    input  logic                rst_n,
    gate_bank_checker_if.master bus
);

    localparam int               SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_END = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
    localparam logic [1:0]       IDX_END = 2'(NUM_VEC - 1);

    state_t           r_state;
    logic [1:0]       r_vec_idx;
    logic [SET_W-1:0] r_settle_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_count;
    logic [1:0]       r_fail_vec;
    logic [5:0]       r_fail_mask;

    logic [5:0]       w_expected;
    logic [5:0]       w_diff;
    logic [CNT_W-1:0] w_err_sat;
    logic [CNT_W-1:0] w_err_after;
    logic [1:0]       w_next_idx;

    gate_ref_model u_ref (
        .i_a        (r_a),
        .i_b        (r_b),
        .o_expected (w_expected)
    );

    assign w_diff     = bus.dut_out ^ w_expected;
    assign w_next_idx = r_vec_idx + 2'd1;

    // Saturating error count as it would stand after the current sample.
    always_comb begin
        w_err_sat   = r_err_count;
        w_err_after = r_err_count;
        if (r_err_count != ERR_MAX) begin
            w_err_sat = r_err_count + CNT_W'(1);
        end else begin
            w_err_sat = r_err_count;
        end
        if (w_diff != 6'b000000) begin
            w_err_after = w_err_sat;
        end else begin
            w_err_after = r_err_count;
        end
    end

    // Run sequencer with all stimulus and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_vec_idx    <= 2'd0;
            r_settle_cnt <= {SET_W{1'b0}};
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= {CNT_W{1'b0}};
            r_fail_vec   <= 2'b00;
            r_fail_mask  <= 6'b000000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state      <= SETTLE;
                        r_vec_idx    <= 2'd0;
                        r_settle_cnt <= {SET_W{1'b0}};
                        r_a          <= 1'b0;
                        r_b          <= 1'b0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_err_count  <= {CNT_W{1'b0}};
                        r_fail_vec   <= 2'b00;
                        r_fail_mask  <= 6'b000000;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SET_END) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    // Error count is still zero only until the first failing vector of the run.
                    if (w_diff != 6'b000000) begin
                        r_err_count <= w_err_sat;
                        r_fail_mask <= r_fail_mask | w_diff;
                        if (r_err_count == {CNT_W{1'b0}}) begin
                            r_fail_vec <= {r_a, r_b};
                        end
                    end
                    if (r_vec_idx == IDX_END) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_after == {CNT_W{1'b0}});
                    end else begin
                        r_state      <= SETTLE;
                        r_vec_idx    <= w_next_idx;
                        r_a          <= w_next_idx[1];
                        r_b          <= w_next_idx[0];
                        r_settle_cnt <= {SET_W{1'b0}};
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;
    assign bus.fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_bank_checker.sv
// Directed bench: a behavioural gate bank with selectable faults drives two checker instances
// (default parameters, and CNT_W=2 / SETTLE_CYCLES=1 for saturation).
module tb_gate_bank_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   mode1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gate_bank_checker_if #(.CNT_W(3)) if1 ();
    gate_bank_checker_if #(.CNT_W(2)) if2 ();

    gate_bank_checker #(.SETTLE_CYCLES(2), .CNT_W(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    gate_bank_checker #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    // Lab gate bank: 0 good, 1 xor stuck at 0, 2 and/nand swapped, 3 all outputs inverted.
    function automatic logic [5:0] bank(input logic a, input logic b, input int mode);
        logic [5:0] g;
        g = {~(a & b), a ^ b, ~b, ~a, a | b, a & b};
        case (mode)
            1:       g[4] = 1'b0;
            2:       g = {g[0], g[4:1], g[5]};
            3:       g = ~g;
            default: g = g;
        endcase
        return g;
    endfunction

    assign if1.dut_out = bank(if1.a, if1.b, mode1);
    assign if2.dut_out = bank(if2.a, if2.b, 3);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run on instance 1 from an idle state, checking latency and final results.
    task automatic run1(input string tag, input logic exp_pass, input logic [2:0] exp_err,
                        input logic [1:0] exp_vec, input logic [5:0] exp_mask);
        int         cyc;
        logic [1:0] ab4;
        ab4 = 2'b00;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        cyc = 1;
        check({tag, " busy_after_start"}, 8'(if1.busy), 8'd1);
        while (!if1.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) ab4 = {if1.a, if1.b};
        end
        check({tag, " done_cycle"}, 8'(cyc), 8'd13);
        check({tag, " vec1_drive"}, 8'(ab4), 8'd1);
        check({tag, " pass"}, 8'(if1.pass), 8'(exp_pass));
        check({tag, " err_count"}, 8'(if1.err_count), 8'(exp_err));
        check({tag, " fail_vec"}, 8'(if1.fail_vec), 8'(exp_vec));
        check({tag, " fail_mask"}, 8'(if1.fail_mask), 8'(exp_mask));
        @(negedge clk);
        check({tag, " done_pulse"}, 8'(if1.done), 8'd0);
        check({tag, " busy_idle"}, 8'(if1.busy), 8'd0);
        check({tag, " ab_idle"}, 8'({if1.a, if1.b}), 8'd0);
        check({tag, " pass_hold"}, 8'(if1.pass), 8'(exp_pass));
    endtask

    initial begin
        int cyc;
        int c2;
        if1.start = 1'b0;
        if2.start = 1'b0;
        mode1     = 0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst a_b", 8'({if1.a, if1.b}), 8'd0);
        check("rst busy_done", 8'({if1.busy, if1.done}), 8'd0);
        check("rst pass", 8'(if1.pass), 8'd0);
        check("rst err_count", 8'(if1.err_count), 8'd0);
        check("rst fail_vec", 8'(if1.fail_vec), 8'd0);
        check("rst fail_mask", 8'(if1.fail_mask), 8'd0);
        rst_n = 1'b1;

        mode1 = 0;
        run1("good", 1'b1, 3'd0, 2'b00, 6'b000000);
        mode1 = 1;
        run1("xor_stuck", 1'b0, 3'd2, 2'b01, 6'b010000);
        mode1 = 2;
        run1("and_nand_swap", 1'b0, 3'd4, 2'b00, 6'b100001);

        // Reset in the middle of vector 2 settle, after vector 1 has already failed.
        mode1 = 1;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (6) @(negedge clk);
        check("midrun ab_v2", 8'({if1.a, if1.b}), 8'd2);
        check("midrun err_before", 8'(if1.err_count), 8'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun ab", 8'({if1.a, if1.b}), 8'd0);
        check("midrun busy", 8'(if1.busy), 8'd0);
        check("midrun err_count", 8'(if1.err_count), 8'd0);
        check("midrun fail_mask", 8'(if1.fail_mask), 8'd0);
        check("midrun fail_vec", 8'(if1.fail_vec), 8'd0);
        rst_n = 1'b1;
        mode1 = 0;
        run1("after_rst", 1'b1, 3'd0, 2'b00, 6'b000000);

        // start held high: ignored while busy, re-accepted in the IDLE cycle after done.
        mode1 = 1;
        run1("pre_hold", 1'b0, 3'd2, 2'b01, 6'b010000);
        mode1 = 0;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!if1.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("hold first_done", 8'(cyc), 8'd13);
        check("hold first_pass", 8'(if1.pass), 8'd1);
        c2 = 0;
        @(negedge clk);
        c2++;
        check("hold idle_busy", 8'(if1.busy), 8'd0);
        @(negedge clk);
        c2++;
        check("hold restart_busy", 8'(if1.busy), 8'd1);
        check("hold restart_pass_clr", 8'(if1.pass), 8'd0);
        while (!if1.done && c2 < 40) begin
            @(negedge clk);
            c2++;
        end
        check("hold done_period", 8'(c2), 8'd14);
        if1.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold released_busy", 8'(if1.busy), 8'd0);

        // Saturation on the narrow counter with every bit wrong.
        @(negedge clk);
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        cyc = 1;
        while (!if2.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("sat done_cycle", 8'(cyc), 8'd9);
        check("sat err_count", 8'(if2.err_count), 8'd3);
        check("sat fail_mask", 8'(if2.fail_mask), 8'h3f);
        check("sat fail_vec", 8'(if2.fail_vec), 8'd0);
        check("sat pass", 8'(if2.pass), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_bank_checker.md
Name: gate_bank_checker

Overview:
- Hardware self-checking stimulus/response engine for the lab's 2-input gate bank (AND, OR, NOT a, NOT b, XOR, NAND).
- On `start`, it drives all four (a,b) vectors into the gate bank and waits a settle interval after each one.
- After each settle it samples the six gate outputs and compares them against a built-in golden model.
- It reports pass/fail, an error count, the first failing vector and an accumulated failing-bit mask, so results can be shown on LEDs without a simulator.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling. Must be >= 1; 0 is illegal.
- CNT_W, 3, width of err_count. The counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a check run; sampled only in IDLE.
- a  out  1  stimulus a to the gate bank (registered).
- b  out  1  stimulus b to the gate bank (registered).
- dut_out  in  6  gate outputs in the order {nand,xor,not_b,not_a,or,and}, i.e. bit0 = and.
- busy  out  1  high from the cycle after start is accepted through the DONE state.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high when the last completed run had zero mismatches.
- err_count  out  CNT_W  number of vectors with at least one mismatching bit.
- fail_vec  out  2  {a,b} of the first failing vector; 0 if none.
- fail_mask  out  6  OR over all vectors of (dut_out XOR expected).

Behaviour:
- Reset (rst_n=0 at a clock edge), including mid-run:
  - state=IDLE; a=b=0; busy=done=pass=0; err_count=0; fail_vec=0; fail_mask=0; vector index and settle counter cleared.
- States:
  - IDLE: waits for start. Outputs hold the previous run's results.
  - SETTLE: a,b held; settle counter runs 0..SETTLE_CYCLES-1.
  - SAMPLE: one cycle; compare happens here.
  - DONE: one cycle; done=1.
- IDLE -> SETTLE when start=1:
  - vector index = 0; a,b = 00; counter = 0.
  - err_count, fail_vec, fail_mask, pass cleared on this same edge.
- SETTLE -> SAMPLE when counter = SETTLE_CYCLES-1.
- In SAMPLE:
  - Compare against expected = {~(a&b), a^b, ~b, ~a, a|b, a&b}, using the currently driven a,b.
  - diff = dut_out ^ expected.
  - If diff != 0:
    - err_count increments, saturating; one increment per vector, not per bit.
    - fail_mask |= diff.
    - fail_vec is loaded with {a,b} only if this is the first failure of the run.
- SAMPLE exits:
  - Index < 3: index++, drive the next vector (order 00, 01, 10, 11), counter = 0, go to SETTLE.
  - Index = 3: go to DONE.
- DONE -> IDLE unconditionally.
  - done=1 for exactly this cycle.
  - pass = (err_count == 0), including any update from the final SAMPLE.
  - a,b return to 00 on entering IDLE.
- Timing: start accepted at edge 0 gives done=1 in cycle 4*(SETTLE_CYCLES+1)+1, which is cycle 13 for the default.
- busy=1 in SETTLE, SAMPLE and DONE.
- start while busy, including during DONE, is ignored (not queued). start in the first IDLE cycle after DONE is accepted.
- dut_out is treated as combinational from a,b. It is sampled only in SAMPLE and ignored otherwise.
- Sampled signals are assumed free of X; no X handling.

Decomposition:
- Package gate_chk_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - bit-index constants for dut_out (IDX_AND=0 .. IDX_NAND=5);
  - the constant NUM_VEC=4.
- One combinational sub-module, gate_ref_model: inputs a,b; output expected[5:0]. It is reused by other lab checkers.

Test Plan:
- Correct gate bank wired to a/b/dut_out, start pulse -> done at cycle 13, pass=1, err_count=0, fail_mask=000000, fail_vec=00.
- dut_out[4] (xor) stuck at 0 -> err_count=2, fail_vec=01, fail_mask=010000, pass=0.
- and/nand bits swapped -> all vectors fail: err_count=4, fail_mask=100001, fail_vec=00.
- CNT_W=2 with all bits inverted -> err_count saturates at 3, fail_mask=111111, pass=0.
- rst_n=0 during vector 2 SETTLE -> next edge: IDLE, a=b=0, busy=0, counters 0. A following start gives a clean pass on the good bank.
- start held high continuously:
  - pulses during busy are ignored;
  - a new run starts in the IDLE cycle after done;
  - results clear on that edge, and done recurs every 14 cycles.
